// File: rtl/bary_weight_sequencer.sv
// Barycentric weight sequencer: computes w0/w1/w2 = (area_k << FRAC) / area_012 by
// time-sharing one external start/done divider, flagging degenerate triangles and divider timeouts.
module bary_weight_sequencer #(
  parameter int AW      = 16,
  parameter int WW      = 32,
  parameter int FRAC    = 6,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_data,
  output logic               in_ready,
  input  logic [AW-1:0]      area_012,
  input  logic [AW-1:0]      area_p12,
  input  logic [AW-1:0]      area_0p2,
  input  logic [AW-1:0]      area_01p,
  output logic               div_start,
  output logic [AW+FRAC-1:0] div_a,
  output logic [AW-1:0]      div_b,
  input  logic               div_done,
  input  logic [WW-1:0]      div_q,
  output logic [WW-1:0]      w0,
  output logic [WW-1:0]      w1,
  output logic [WW-1:0]      w2,
  output logic               interp_done,
  output logic               degenerate,
  output logic               timeout_err
);

  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  logic [1:0]         idx_r;
  logic [WDW-1:0]     wd_r;
  logic [AW-1:0]      a0p2_r;
  logic [AW-1:0]      a01p_r;
  logic               div_start_r;
  logic [AW+FRAC-1:0] div_a_r;
  logic [AW-1:0]      div_b_r;
  logic [WW-1:0]      w0_r;
  logic [WW-1:0]      w1_r;
  logic [WW-1:0]      w2_r;
  logic               interp_done_r;
  logic               degenerate_r;
  logic               timeout_err_r;

  // Dividend is the sub-area shifted into the weight's fixed-point format.
  function automatic logic [AW+FRAC-1:0] scale_area(input logic [AW-1:0] area);
    return {area, {FRAC{1'b0}}};
  endfunction

  assign in_ready    = (state_r == IDLE);
  assign div_start   = div_start_r;
  assign div_a       = div_a_r;
  assign div_b       = div_b_r;
  assign w0          = w0_r;
  assign w1          = w1_r;
  assign w2          = w2_r;
  assign interp_done = interp_done_r;
  assign degenerate  = degenerate_r;
  assign timeout_err = timeout_err_r;

  // Sequencer FSM; divider operands and pulses are registered on entry to ISSUE/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      idx_r         <= 2'd0;
      wd_r          <= {WDW{1'b0}};
      a0p2_r        <= {AW{1'b0}};
      a01p_r        <= {AW{1'b0}};
      div_start_r   <= 1'b0;
      div_a_r       <= {(AW+FRAC){1'b0}};
      div_b_r       <= {AW{1'b0}};
      w0_r          <= {WW{1'b0}};
      w1_r          <= {WW{1'b0}};
      w2_r          <= {WW{1'b0}};
      interp_done_r <= 1'b0;
      degenerate_r  <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      div_start_r   <= 1'b0;
      interp_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_data) begin
            a0p2_r        <= area_0p2;
            a01p_r        <= area_01p;
            div_b_r       <= area_012;
            idx_r         <= 2'd0;
            timeout_err_r <= 1'b0;
            if (area_012 == {AW{1'b0}}) begin
              w0_r          <= {WW{1'b0}};
              w1_r          <= {WW{1'b0}};
              w2_r          <= {WW{1'b0}};
              degenerate_r  <= 1'b1;
              interp_done_r <= 1'b1;
              state_r       <= DONE;
            end else begin
              degenerate_r <= 1'b0;
              div_a_r      <= scale_area(area_p12);
              div_start_r  <= 1'b1;
              state_r      <= ISSUE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          wd_r    <= {WDW{1'b0}};
          state_r <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            case (idx_r)
              2'd0:    w0_r <= div_q;
              2'd1:    w1_r <= div_q;
              default: w2_r <= div_q;
            endcase
            if (idx_r == 2'd2) begin
              interp_done_r <= 1'b1;
              state_r       <= DONE;
            end else begin
              idx_r       <= idx_r + 2'd1;
              div_a_r     <= scale_area((idx_r == 2'd0) ? a0p2_r : a01p_r);
              div_start_r <= 1'b1;
              state_r     <= ISSUE;
            end
          end else if (wd_r == WD_LAST) begin
            timeout_err_r <= 1'b1;
            interp_done_r <= 1'b1;
            state_r       <= DONE;
          end else begin
            wd_r <= wd_r + WDW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bary_weight_sequencer.sv
// Directed bench for bary_weight_sequencer: divider model with fixed latency, scoreboard of
// expected divider operands and weight sets, cycle-exact pulse timing checks.
module tb_bary_weight_sequencer;
  localparam int AW = 16;
  localparam int WW = 32;
  localparam int FRAC = 6;
  localparam int TIMEOUT = 64;
  localparam int L = 4;

  typedef struct {
    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    logic [WW-1:0] w2;
    logic          deg;
    logic          tout;
  } res_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_data = 1'b0;
  logic               in_ready;
  logic [AW-1:0]      area_012 = '0, area_p12 = '0, area_0p2 = '0, area_01p = '0;
  logic               div_start;
  logic [AW+FRAC-1:0] div_a;
  logic [AW-1:0]      div_b;
  logic               div_done = 1'b0;
  logic [WW-1:0]      div_q = '0;
  logic [WW-1:0]      w0, w1, w2;
  logic               interp_done, degenerate, timeout_err;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int resp_left = 1000;
  int stray_at = -1;
  bit hold_chk = 1'b1;

  res_t               exp_q[$];
  logic [AW+FRAC-1:0] expa_q[$];
  logic [AW-1:0]      expb_q[$];
  int                 start_q[$];
  int                 done_q[$];

  bary_weight_sequencer #(.AW(AW), .WW(WW), .FRAC(FRAC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_data(valid_data), .in_ready(in_ready),
    .area_012(area_012), .area_p12(area_p12), .area_0p2(area_0p2), .area_01p(area_01p),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_q(div_q),
    .w0(w0), .w1(w1), .w2(w2), .interp_done(interp_done), .degenerate(degenerate),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic res_t mk_res(input int a012, input int p12, input int p0p2, input int p01p);
    res_t r;
    r.tout = 1'b0;
    if (a012 == 0) begin
      r.w0 = '0; r.w1 = '0; r.w2 = '0; r.deg = 1'b1;
    end else begin
      r.w0 = WW'((p12 * 64) / a012);
      r.w1 = WW'((p0p2 * 64) / a012);
      r.w2 = WW'((p01p * 64) / a012);
      r.deg = 1'b0;
    end
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one area set and wait for acceptance; t is the accept cycle.
  task automatic send(input int a012, input int p12, input int p0p2, input int p01p,
                      input bit hold, input bit push_res, input res_t e, output int t);
    bit acc;
    acc = 1'b0;
    t = -1;
    valid_data = 1'b1;
    area_012 = AW'(a012); area_p12 = AW'(p12); area_0p2 = AW'(p0p2); area_01p = AW'(p01p);
    if (a012 != 0) begin
      expa_q.push_back((AW+FRAC)'(p12 * 64));  expb_q.push_back(AW'(a012));
      expa_q.push_back((AW+FRAC)'(p0p2 * 64)); expb_q.push_back(AW'(a012));
      expa_q.push_back((AW+FRAC)'(p01p * 64)); expb_q.push_back(AW'(a012));
    end
    if (push_res) exp_q.push_back(e);
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        t = cyc;
        acc = 1'b1;
      end
      step(1);
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    if (!hold) valid_data = 1'b0;
  endtask

  task automatic wait_done(input int n, input int bound);
    int i;
    for (i = 0; i < bound && done_q.size() < n; i++) step(1);
    if (done_q.size() < n) chk("done_wait_timeout", 64'(done_q.size()), 64'(n));
  endtask

  task automatic clear_all();
    expa_q.delete(); expb_q.delete(); start_q.delete(); done_q.delete(); exp_q.delete();
  endtask

  // Divider model: answers L cycles after div_start, optionally goes silent, injects strays.
  initial begin
    logic [AW+FRAC-1:0] ma;
    logic [AW-1:0]      mb;
    forever begin
      @(posedge clk);
      #1;
      div_done = 1'b0;
      if (cyc == stray_at) begin
        div_done = 1'b1;
        div_q = 32'hDEAD_BEEF;
      end else if (div_start) begin
        if (expa_q.size() == 0) begin
          chk("unexpected_div_start", 64'd1, 64'd0);
        end else begin
          chk("div_a", 64'(div_a), 64'(expa_q.pop_front()));
          chk("div_b", 64'(div_b), 64'(expb_q.pop_front()));
        end
        if (resp_left > 0) begin
          resp_left--;
          ma = div_a;
          mb = div_b;
          repeat (L) @(posedge clk);
          #1;
          if (hold_chk) chk("div_a_held", 64'(div_a), 64'(ma));
          div_done = 1'b1;
          div_q = WW'(ma / mb);
        end
      end
    end
  end

  // Output monitor: records pulse cycles and scores each completed weight set.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (div_start) start_q.push_back(cyc);
      if (interp_done) begin
        done_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_interp_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("w0", 64'(w0), 64'(e.w0));
          chk("w1", 64'(w1), 64'(e.w1));
          chk("w2", 64'(w2), 64'(e.w2));
          chk("degenerate", 64'(degenerate), 64'(e.deg));
          chk("timeout_err", 64'(timeout_err), 64'(e.tout));
        end
      end
    end
  end

  initial begin
    int t, t2;
    res_t e;
    step(3);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", {w0, w1}, 64'd0);
    chk("rst_w2_flags", {w2, div_start, interp_done, degenerate, timeout_err}, 64'd0);
    rst = 1'b0;
    step(1);
    chk("post_rst_no_start", 64'(div_start), 64'd0);

    // Nominal set, plus a stray div_done while in DONE.
    send(64, 16, 16, 32, 1'b0, 1'b1, mk_res(64, 16, 16, 32), t);
    stray_at = t + 16;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    wait_done(1, 100);
    step(3);
    chk("nom_starts", 64'(start_q.size()), 64'd3);
    if (start_q.size() == 3) begin
      chk("nom_start0", 64'(start_q[0]), 64'(t + 1));
      chk("nom_start1", 64'(start_q[1]), 64'(t + 6));
      chk("nom_start2", 64'(start_q[2]), 64'(t + 11));
    end
    if (done_q.size() > 0) chk("nom_done_cycle", 64'(done_q[0]), 64'(t + 16));
    chk("nom_done_count", 64'(done_q.size()), 64'd1);
    chk("stray_done_w0", 64'(w0), 64'd16);
    chk("stray_done_w2", 64'(w2), 64'd32);
    clear_all();

    // Degenerate triangle, then a stray div_done in IDLE.
    send(0, 5, 7, 9, 1'b0, 1'b1, mk_res(0, 5, 7, 9), t);
    chk("deg_done_t1", 64'(interp_done), 64'd1);
    step(1);
    chk("deg_ready_t2", 64'(in_ready), 64'd1);
    stray_at = cyc + 1;
    step(3);
    chk("deg_no_start", 64'(start_q.size()), 64'd0);
    chk("stray_idle_w0", 64'(w0), 64'd0);
    chk("stray_idle_done", 64'(done_q.size()), 64'd1);
    chk("stray_idle_ready", 64'(in_ready), 64'd1);
    clear_all();

    // Back-to-back with valid_data held high throughout.
    send(100, 25, 50, 25, 1'b1, 1'b1, mk_res(100, 25, 50, 25), t);
    send(200, 10, 190, 0, 1'b0, 1'b1, mk_res(200, 10, 190, 0), t2);
    chk("b2b_accept", 64'(t2), 64'(t + 17));
    wait_done(2, 100);
    step(2);
    if (done_q.size() == 2) chk("b2b_done2", 64'(done_q[1]), 64'(t2 + 16));
    chk("b2b_starts", 64'(start_q.size()), 64'd6);
    clear_all();

    // Timeout on the second division; w1/w2 keep the previous set's values.
    resp_left = 1;
    e = mk_res(50, 10, 20, 30);
    e.w1 = mk_res(200, 10, 190, 0).w1;
    e.w2 = mk_res(200, 10, 190, 0).w2;
    e.tout = 1'b1;
    send(50, 10, 20, 30, 1'b0, 1'b1, e, t);
    wait_done(1, 200);
    if (done_q.size() > 0) chk("tout_done_cycle", 64'(done_q[0]), 64'(t + 71));
    stray_at = cyc + 2;
    step(5);
    chk("tout_starts", 64'(start_q.size()), 64'd2);
    chk("tout_done_count", 64'(done_q.size()), 64'd1);
    chk("tout_late_w0", 64'(w0), 64'd12);
    chk("tout_flag_held", 64'(timeout_err), 64'd1);
    resp_left = 1000;
    clear_all();

    // Reset during the second division, then a fresh set.
    hold_chk = 1'b0;
    send(64, 16, 16, 32, 1'b0, 1'b0, e, t);
    step(7);
    rst = 1'b1;
    step(1);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_w", {w0, w1}, 64'd0);
    chk("midrst_w2_flags", {w2, div_start, interp_done, degenerate, timeout_err}, 64'd0);
    chk("midrst_div_ops", {div_a, div_b}, 64'd0);
    rst = 1'b0;
    step(1);
    chk("midrst_no_start", 64'(div_start), 64'd0);
    step(4);
    chk("midrst_no_done", 64'(done_q.size()), 64'd0);
    clear_all();
    hold_chk = 1'b1;
    send(80, 40, 20, 20, 1'b0, 1'b1, mk_res(80, 40, 20, 20), t);
    wait_done(1, 100);
    if (done_q.size() > 0) chk("fresh_done_cycle", 64'(done_q[0]), 64'(t + 16));
    step(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bary_weight_sequencer.md
Name: bary_weight_sequencer

Overview:
- Sequences barycentric weight computation for the rasterizer: w0, w1 and w2 are area_p12, area_0p2 and area_01p divided by area_012, in fixed point.
- Time-shares one external multi-cycle fixed-point divider across the three divisions using a start/done handshake.
- Sits between triangle-area setup and pixel attribute interpolation.
- Flags degenerate triangles (area_012 == 0) and divider timeouts without using the divider for the degenerate case.

Parameters:
- AW, 16, area operand width (unsigned)
- WW, 32, weight/quotient width
- FRAC, 6, fractional bits of weights; dividend = area << FRAC
- TIMEOUT, 64, max cycles in WAIT before abort

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_data  in  1  area set valid
- in_ready  out  1  block can accept an area set
- area_012  in  AW  full triangle area (divisor)
- area_p12  in  AW  sub-area for w0
- area_0p2  in  AW  sub-area for w1
- area_01p  in  AW  sub-area for w2
- div_start  out  1  one-cycle divider start pulse
- div_a  out  AW+FRAC  dividend, {area_k, FRAC'b0}
- div_b  out  AW  divisor, latched area_012
- div_done  in  1  divider result-valid pulse
- div_q  in  WW  divider quotient
- w0, w1, w2  out  WW each  weights
- interp_done  out  1  one-cycle completion pulse
- degenerate  out  1  last set had area_012 == 0
- timeout_err  out  1  last set aborted on divider timeout

Behaviour:
- Reset (synchronous, highest priority, including mid-operation):
  - state=IDLE, idx=0, w0/w1/w2=0, interp_done=0, degenerate=0, timeout_err=0, div_start=0, div_a=0, div_b=0, watchdog=0.
  - No div_start in the cycle after rst deasserts.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1; in every other state in_ready=0.
  - On valid_data: latch all four areas, clear degenerate and timeout_err, set idx=0.
  - If area_012 == 0: w0/w1/w2 <= 0, degenerate <= 1, go to DONE. The divider is not started.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_start=1 for exactly this cycle.
  - div_a = latched area selected by idx (0:p12, 1:0p2, 2:01p) << FRAC; div_b = latched area_012.
  - div_a and div_b are held stable until the matching div_done.
  - Clear watchdog, go to WAIT.
- WAIT:
  - On div_done: w[idx] <= div_q, captured unmodified (no clamp, no sign extension).
  - Then, if idx == 2, go to DONE; else idx++ and go to ISSUE.
  - Otherwise watchdog++. When watchdog == TIMEOUT-1 without div_done: timeout_err <= 1, go to DONE. Weights already written are kept; unwritten ones keep their prior value.
  - div_done and watchdog expiry in the same cycle: div_done wins.
- DONE: interp_done=1 for this single cycle, then go to IDLE.
- div_done outside WAIT is ignored; no weight changes.
- valid_data outside IDLE is ignored; no queuing. The source must hold valid_data until in_ready.
- w0/w1/w2/degenerate/timeout_err hold their values from DONE until the next accepted set.
- Latency, with divider latency L (div_done L cycles after div_start) and acceptance at cycle T:
  - div_start at T+1, T+L+2 and T+2L+3.
  - interp_done at T+3L+4.
  - Next acceptance possible at T+3L+5.
- Degenerate path: interp_done at T+1, next accept at T+2.

Test Plan:
- Nominal: divider model with L=4. area_012=64, p12=16, 0p2=16, 01p=32, accept at T -> div_a 1024/1024/2048 with div_b=64; w0=16, w1=16, w2=32; interp_done only at T+16; exactly 3 div_start pulses.
- Degenerate: area_012=0, p12=5 -> no div_start; interp_done at T+1; w0/w1/w2=0; degenerate=1; in_ready high again at T+2.
- Back-to-back: valid_data held high with two sets -> second accepted at T+17; valid_data during busy is ignored; both result sets are correct and distinct.
- Timeout: divider never answers the second request (TIMEOUT=64) -> timeout_err=1, w0 updated, w1/w2 unchanged, one interp_done pulse; a spurious late div_done is ignored.
- Reset mid-WAIT: rst asserted during the second division -> next cycle all outputs 0, in_ready=1, no div_start; a fresh set then completes normally.
- Stray div_done in IDLE and DONE -> no weight change, no state change.
